// File: rtl/pio_poll_pkg.sv
// pio_poll_scheduler shared types and constants.
// Optional build macro: PIO_POLL_TSTAMP_EN (change timestamp).
package pio_poll_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    CAPTURE,
    UPDATE
  } state_t;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  // Bits needed to hold the values 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pio_poll_if.sv
// Avalon-MM read port between the poller and the PIO s1 slave.
// Optional build macro: PIO_POLL_TSTAMP_EN (not used here).
interface pio_poll_if;

  logic [1:0]  pio_address;
  logic [31:0] pio_readdata;

  modport master (
    output pio_address,
    input  pio_readdata
  );

  modport slave (
    input  pio_address,
    output pio_readdata
  );

endinterface

// File: rtl/pio_poll_debounce.sv
// Debounce of polled samples, stable snapshot and sticky change mask.
// Optional build macro: PIO_POLL_TSTAMP_EN (not used here).
module pio_poll_debounce
  import pio_poll_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEBOUNCE_N = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_strobe,
  input  logic              i_irq_clear,
  input  logic [DATA_W-1:0] i_sample,
  output logic [DATA_W-1:0] o_stable,
  output logic [DATA_W-1:0] o_mask,
  output logic              o_irq,
  output logic              o_change
);

  localparam int CW = cnt_w(DEBOUNCE_N + 1);
  localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_N);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  logic [DATA_W-1:0] r_cand;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_stable;
  logic [DATA_W-1:0] r_mask;
  logic              r_irq;

  logic [CW-1:0]     w_cnt_nxt;
  logic [DATA_W-1:0] w_diff;
  logic [DATA_W-1:0] w_mask_nxt;
  logic              w_change;

  // Saturating count step; a fresh change beats a same-cycle clear.
  always_comb begin
    w_cnt_nxt  = C_ONE;
    if (i_sample == r_cand)
      w_cnt_nxt = (r_cnt == C_MAX) ? C_MAX : r_cnt + C_ONE;
    w_diff     = i_sample ^ r_stable;
    w_change   = i_strobe && (w_cnt_nxt == C_MAX) && (w_diff != '0);
    w_mask_nxt = (i_irq_clear ? '0 : r_mask) |
                 (w_change ? w_diff : '0);
  end

  // Candidate tracking, stable snapshot, mask and registered irq.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cand   <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
      r_mask   <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (i_strobe) begin
        r_cand <= i_sample;
        r_cnt  <= w_cnt_nxt;
      end
      if (w_change)
        r_stable <= i_sample;
      r_mask <= w_mask_nxt;
      r_irq  <= |w_mask_nxt;
    end
  end

  assign o_stable = r_stable;
  assign o_mask   = r_mask;
  assign o_irq    = r_irq;
  assign o_change = w_change;

endmodule

// File: rtl/pio_poll_scheduler.sv
// Periodic PIO read master with debounce and change interrupt.
// Optional build macro: PIO_POLL_TSTAMP_EN adds o_change_tstamp.
module pio_poll_scheduler
  import pio_poll_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int POLL_DIV   = 5000,
  parameter int DEBOUNCE_N = 3,
  parameter int READ_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_enable,
  input  logic              i_poll_now,
  input  logic              i_irq_clear,
  pio_poll_if.master        pio,
  output logic              o_busy,
  output logic [DATA_W-1:0] o_sample_out,
  output logic              o_sample_valid,
  output logic [DATA_W-1:0] o_stable_value,
  output logic [DATA_W-1:0] o_changed_mask,
  output logic              o_irq
`ifdef PIO_POLL_TSTAMP_EN
  ,
  output logic [31:0]       o_change_tstamp
`endif
);

  localparam int PW = cnt_w(POLL_DIV);
  localparam int LW = cnt_w(READ_LAT);
  localparam logic [PW-1:0] PRELOAD  = PW'(POLL_DIV - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(READ_LAT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [PW-1:0]     r_presc;
  logic              r_pending;
  logic [LW-1:0]     r_lat;
  logic [DATA_W-1:0] r_sample;
  logic              r_valid;

  logic w_tick;
  logic w_take;
  logic w_cap;
  logic w_change;
  logic w_unused;

  assign w_tick   = i_enable && (r_presc == '0);
  assign w_take   = (r_state == IDLE) && r_pending;
  assign w_cap    = (r_state == WAIT) && (r_lat == LAT_LAST);
  assign w_unused = ^pio.pio_readdata;

  // Poll prescaler; parked at the reload value while disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_presc <= PRELOAD;
    else if (!i_enable || w_tick)
      r_presc <= PRELOAD;
    else
      r_presc <= r_presc - PW'(1);
  end

  // Single request flag; new requests win over the IDLE hand-off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_pending <= 1'b0;
    else if (w_tick || i_poll_now)
      r_pending <= 1'b1;
    else if (w_take)
      r_pending <= 1'b0;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // FSM next state.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (r_pending) w_next = ADDR;
      ADDR:    w_next = WAIT;
      WAIT:    if (w_cap) w_next = CAPTURE;
      CAPTURE: w_next = UPDATE;
      UPDATE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Read-latency counter, restarted whenever we are not waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_lat <= '0;
    else if (r_state != WAIT || w_cap)
      r_lat <= '0;
    else
      r_lat <= r_lat + LW'(1);
  end

  // Latch readdata at the end of the wait so it shows in CAPTURE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_cap;
      if (w_cap)
        r_sample <= pio.pio_readdata[DATA_W-1:0];
    end
  end

  pio_poll_debounce #(
    .DATA_W     (DATA_W),
    .DEBOUNCE_N (DEBOUNCE_N)
  ) u_debounce (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_strobe    (r_state == UPDATE),
    .i_irq_clear (i_irq_clear),
    .i_sample    (r_sample),
    .o_stable    (o_stable_value),
    .o_mask      (o_changed_mask),
    .o_irq       (o_irq),
    .o_change    (w_change)
  );

`ifdef PIO_POLL_TSTAMP_EN
  logic [31:0] r_tcnt;
  logic [31:0] r_tstamp;

  // Free-running cycle counter and snapshot on stable change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tcnt   <= '0;
      r_tstamp <= '0;
    end else begin
      r_tcnt <= r_tcnt + 32'd1;
      if (w_change)
        r_tstamp <= r_tcnt;
    end
  end

  assign o_change_tstamp = r_tstamp;
`endif

  assign pio.pio_address = PIO_DATA_ADDR;
  assign o_busy          = (r_state != IDLE);
  assign o_sample_out    = r_sample;
  assign o_sample_valid  = r_valid;

endmodule

// File: tb/tb_pio_poll_scheduler.sv
// Self-checking bench for pio_poll_scheduler (POLL_DIV=8, DEBOUNCE_N=3).
// Optional build macro: PIO_POLL_TSTAMP_EN enables timestamp checks.
module tb_pio_poll_scheduler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       poll_now = 1'b0;
  logic       irq_clear = 1'b0;
  logic       busy;
  logic       valid;
  logic       irq;
  logic [7:0] sample;
  logic [7:0] stable;
  logic [7:0] mask;
  logic [7:0] pio_val = 8'h00;

`ifdef PIO_POLL_TSTAMP_EN
  logic [31:0] tstamp;
  logic [31:0] tc;
  logic [31:0] upd_tc = 32'd0;
`endif

  typedef struct {
    logic [7:0] s;
    logic [7:0] st;
    logic [7:0] m;
    logic       irq;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  pio_poll_if pio();

  pio_poll_scheduler #(
    .DATA_W     (8),
    .POLL_DIV   (8),
    .DEBOUNCE_N (3),
    .READ_LAT   (1)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_enable       (enable),
    .i_poll_now     (poll_now),
    .i_irq_clear    (irq_clear),
    .pio            (pio.master),
    .o_busy         (busy),
    .o_sample_out   (sample),
    .o_sample_valid (valid),
    .o_stable_value (stable),
    .o_changed_mask (mask),
    .o_irq          (irq)
`ifdef PIO_POLL_TSTAMP_EN
    ,
    .o_change_tstamp (tstamp)
`endif
  );

  always #5 clk = ~clk;

  // PIO slave model: registered data, one cycle read latency.
  always @(posedge clk) pio.pio_readdata <= {24'h0, pio_val};

`ifdef PIO_POLL_TSTAMP_EN
  always @(posedge clk or negedge reset_n)
    if (!reset_n) tc <= 32'd0;
    else tc <= tc + 32'd1;
`endif

  // Scoreboard monitor: pop on each sample, check debounce result after UPDATE.
  always begin
    @(negedge clk);
    if (reset_n && valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_sample got %h", sample);
      end else begin
        mon_e = q.pop_front();
        checks++;
        if (sample !== mon_e.s) begin
          errors++;
          $display("FAIL sample got %h exp %h", sample, mon_e.s);
        end
        checks++;
        if (pio.pio_address !== 2'd0) begin
          errors++;
          $display("FAIL address got %h exp 0", pio.pio_address);
        end
        @(negedge clk);
`ifdef PIO_POLL_TSTAMP_EN
        upd_tc = tc;
`endif
        @(negedge clk);
        checks++;
        if (stable !== mon_e.st) begin
          errors++;
          $display("FAIL stable got %h exp %h", stable, mon_e.st);
        end
        checks++;
        if (mask !== mon_e.m) begin
          errors++;
          $display("FAIL mask got %h exp %h", mask, mon_e.m);
        end
        checks++;
        if (irq !== mon_e.irq) begin
          errors++;
          $display("FAIL irq got %b exp %b", irq, mon_e.irq);
        end
      end
    end
  end

  task automatic poll(input logic [7:0] v, input logic [7:0] st,
                      input logic [7:0] m, input logic ir, input bit clr);
    exp_t x;
    int   n;
    pio_val = v;
    x.s = v; x.st = st; x.m = m; x.irq = ir;
    q.push_back(x);
    poll_now = 1'b1;
    @(negedge clk);
    poll_now = 1'b0;
    n = 0;
    while (!valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!valid) begin
      checks++; errors++;
      $display("FAIL poll_timeout got none exp sample_valid");
    end
    @(negedge clk);
    if (clr) irq_clear = 1'b1;
    @(negedge clk);
    irq_clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, valid, irq} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000", {busy, valid, irq});
    end
    checks++;
    if ({sample, stable, mask} !== 24'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", {sample, stable, mask});
    end
    checks++;
    if (pio.pio_address !== 2'd0) begin
      errors++;
      $display("FAIL reset_addr got %h exp 0", pio.pio_address);
    end
  endtask

  task automatic test_periodic();
    int t[4];
    int nv = 0;
    exp_t x;
    x.s = 8'h00; x.st = 8'h00; x.m = 8'h00; x.irq = 1'b0;
    for (int k = 0; k < 4; k++) q.push_back(x);
    pio_val = 8'h00;
    enable = 1'b1;
    for (int i = 1; i <= 60 && nv < 4; i++) begin
      @(negedge clk);
      if (valid) begin
        t[nv] = i;
        nv++;
      end
    end
    enable = 1'b0;
    checks++;
    if (nv != 4) begin
      errors++;
      $display("FAIL periodic_count got %0d exp 4", nv);
    end else begin
      checks++;
      if (t[0] != 11) begin
        errors++;
        $display("FAIL periodic_first got %0d exp 11", t[0]);
      end
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (t[k] - t[k-1] != 8) begin
          errors++;
          $display("FAIL periodic_gap got %0d exp 8", t[k] - t[k-1]);
        end
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_glitch();
    poll(8'h01, 8'h00, 8'h00, 1'b0, 1'b0);
    poll(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    poll(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({stable, irq} !== 9'h0) begin
      errors++;
      $display("FAIL glitch got %h exp 0", {stable, irq});
    end
  endtask

  task automatic test_step();
    poll(8'hA5, 8'h00, 8'h00, 1'b0, 1'b0);
    poll(8'hA5, 8'h00, 8'h00, 1'b0, 1'b0);
    poll(8'hA5, 8'hA5, 8'hA5, 1'b1, 1'b0);
`ifdef PIO_POLL_TSTAMP_EN
    checks++;
    if (tstamp !== upd_tc) begin
      errors++;
      $display("FAIL tstamp got %h exp %h", tstamp, upd_tc);
    end
`endif
    irq_clear = 1'b1;
    @(negedge clk);
    irq_clear = 1'b0;
    checks++;
    if ({mask, irq} !== 9'h0) begin
      errors++;
      $display("FAIL step_clear got %h exp 0", {mask, irq});
    end
    checks++;
    if (stable !== 8'hA5) begin
      errors++;
      $display("FAIL step_hold got %h exp a5", stable);
    end
  endtask

  task automatic test_coalesce();
    int t[2];
    int nv = 0;
    exp_t x;
    x.s = 8'hA5; x.st = 8'hA5; x.m = 8'h00; x.irq = 1'b0;
    q.push_back(x);
    q.push_back(x);
    pio_val = 8'hA5;
    for (int i = 0; i < 30; i++) begin
      poll_now = (i == 0 || i == 2 || i == 3 || i == 5);
      @(negedge clk);
      if (valid) begin
        if (nv < 2) t[nv] = i + 1;
        nv++;
      end
    end
    poll_now = 1'b0;
    checks++;
    if (nv != 2) begin
      errors++;
      $display("FAIL coalesce_count got %0d exp 2", nv);
    end else begin
      checks++;
      if (t[0] != 4) begin
        errors++;
        $display("FAIL coalesce_lat got %0d exp 4", t[0]);
      end
      checks++;
      if (t[1] - t[0] != 5) begin
        errors++;
        $display("FAIL coalesce_gap got %0d exp 5", t[1] - t[0]);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clear_same_cycle();
    poll(8'h00, 8'hA5, 8'h00, 1'b0, 1'b0);
    poll(8'h00, 8'hA5, 8'h00, 1'b0, 1'b0);
    poll(8'h00, 8'h00, 8'hA5, 1'b1, 1'b0);
    poll(8'h0F, 8'h00, 8'hA5, 1'b1, 1'b0);
    poll(8'h0F, 8'h00, 8'hA5, 1'b1, 1'b0);
    poll(8'h0F, 8'h0F, 8'h0F, 1'b1, 1'b1);
    checks++;
    if ({mask, irq} !== {8'h0F, 1'b1}) begin
      errors++;
      $display("FAIL clear_race got %h exp 1f", {mask, irq});
    end
  endtask

  task automatic test_reset_mid();
    exp_t x;
    int   n;
    pio_val = 8'h3C;
    poll_now = 1'b1;
    @(negedge clk);
    poll_now = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got %b exp 1", busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, valid, irq, sample, stable, mask} !== 27'h0) begin
      errors++;
      $display("FAIL mid_reset got %h exp 0",
               {busy, valid, irq, sample, stable, mask});
    end
`ifdef PIO_POLL_TSTAMP_EN
    checks++;
    if (tstamp !== 32'h0) begin
      errors++;
      $display("FAIL mid_tstamp got %h exp 0", tstamp);
    end
`endif
    repeat (2) @(negedge clk);
    x.s = 8'h3C; x.st = 8'h00; x.m = 8'h00; x.irq = 1'b0;
    q.push_back(x);
    enable = 1'b1;
    reset_n = 1'b1;
    n = 0;
    while (!valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    enable = 1'b0;
    checks++;
    if (n != 11) begin
      errors++;
      $display("FAIL post_reset_lat got %0d exp 11", n);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_periodic();
    test_glitch();
    test_step();
    test_coalesce();
    test_clear_same_cycle();
    test_reset_mid();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover got %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pio_poll_scheduler.md
Name: pio_poll_scheduler

Overview:
Avalon-MM read-master controller that periodically samples one 8-bit input PIO slave with a fixed 1-cycle registered read latency. It debounces each sample, keeps a stable-value snapshot and a changed-bit mask, and raises a level IRQ toward the HPS when the stable value changes. It sits between the PIO s1 read port and the drone control logic, which it relieves of polling.

Parameters:
DATA_W, 8, width of the sampled PIO field (readdata[DATA_W-1:0]); legal range 1..32.
POLL_DIV, 5000, clk cycles between automatic polls; must be >=4.
DEBOUNCE_N, 3, number of consecutive identical samples required to accept a value; 1 = no debounce.
READ_LAT, 1, slave read latency in cycles; must be >=1.

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
enable  in  1  automatic polling enable
poll_now  in  1  single-cycle request for an immediate poll
irq_clear  in  1  single-cycle pulse; clears changed_mask and irq
pio_address  out  2  slave address; always 0 (data register)
pio_readdata  in  32  slave readdata
busy  out  1  high from ADDR through UPDATE
sample_out  out  DATA_W  last raw sample
sample_valid  out  1  single-cycle pulse when sample_out updates
stable_value  out  DATA_W  debounced value
changed_mask  out  DATA_W  sticky bits that changed in stable_value since the last clear
irq  out  1  level interrupt; high while changed_mask != 0

Behaviour:
- Reset values: all outputs 0, pio_address 0, state IDLE, prescaler = POLL_DIV-1, pending 0, candidate 0, debounce count 0.
- Prescaler: while enable=1, decrements each cycle; at 0 it reloads POLL_DIV-1 and sets pending. While enable=0 it holds the reload value.
- poll_now=1 sets pending. pending is a single flag, so requests arriving during busy coalesce into at most one follow-up poll.
- FSM:
  - IDLE: if pending, clear pending and go to ADDR.
  - ADDR: drive pio_address=0 for 1 cycle, then go to WAIT.
  - WAIT: count READ_LAT cycles, then go to CAPTURE.
  - CAPTURE: register pio_readdata[DATA_W-1:0] into sample_out and pulse sample_valid, then go to UPDATE.
  - UPDATE: debounce step, then return to IDLE.
- Poll latency: from pending seen in IDLE to sample_valid is READ_LAT+2 cycles.
- Debounce in UPDATE:
  - If sample == candidate, count = min(count+1, DEBOUNCE_N); otherwise candidate = sample and count = 1.
  - If the resulting count == DEBOUNCE_N and candidate != stable_value: stable_value <= candidate and changed_mask <= changed_mask | (candidate ^ stable_value).
- irq is registered: irq = (next changed_mask != 0).
- irq_clear in the same cycle as an UPDATE change: the mask takes only the new diff bits and irq stays 1; a new change wins over the clear.
- Deasserting enable mid-poll: the in-flight poll completes; pending already set is still serviced.
- Reset mid-poll: immediate return to IDLE with all state cleared. The first poll after reset produces a stable_value change only if the input is nonzero for DEBOUNCE_N samples.
- Arithmetic: the prescaler and READ_LAT counters use $clog2 widths; the debounce counter saturates and never wraps.

Optional Feature:
PIO_POLL_TSTAMP_EN:
- Defined: adds a 32-bit free-running cycle counter, reset to 0 and wrapping at 2^32, and an output change_tstamp[31:0]. change_tstamp is loaded with the counter value in the UPDATE cycle that modifies stable_value.
- Undefined: no counter and no port.

Decomposition:
- Package pio_poll_pkg:
  - FSM state enum (IDLE, ADDR, WAIT, CAPTURE, UPDATE)
  - constant PIO_DATA_ADDR = 2'd0
  - localparam helper for counter widths
- One sub-module, pio_poll_debounce: candidate, count and stable/mask update, driven by a sample strobe. The FSM and prescaler stay in the top module.

Test Plan:
- POLL_DIV=8, enable=1, PIO model input 8'h00: sample_valid every 8 cycles, irq stays 0, pio_address always 0.
- Input steps to 8'hA5 with DEBOUNCE_N=3: stable_value=8'hA5 and changed_mask=8'hA5 after the 3rd post-step sample; irq rises in that UPDATE+1 cycle; irq_clear drops both.
- Glitch: input 8'h01 for one poll, then back to 8'h00: stable_value is unchanged and irq stays 0.
- enable=0 with poll_now pulsed 3 times during one busy window: exactly two polls occur (the current one plus one coalesced), each READ_LAT+2 cycles from IDLE.
- irq_clear asserted in the same cycle as a change 8'h00->8'h0F: changed_mask=8'h0F and irq stays 1.
- reset_n pulled low during WAIT: outputs go to 0 at once; after release with POLL_DIV=8, the first sample_valid occurs at cycle 8+READ_LAT+2; with PIO_POLL_TSTAMP_EN, change_tstamp equals the counter at the change.
